// File: rtl/typing_scorer.sv
// typing_scorer: scores a typing run against a target text.
// Counts correct and wrong key presses and times the run in whole seconds.
// When the run ends it computes words-per-minute with a 14-step restoring divider.
// Optional macro TYPING_STRICT_EN: a wrong press also advances char_idx, so there is no retry.
module typing_scorer #(
    parameter int CLK_HZ     = 100000000,
    parameter int TEXT_LEN   = 64,
    parameter int IDX_W      = 6,
    parameter int TIME_LIMIT = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       state,
    input  logic [511:0]     key_down,
    input  logic [8:0]       last_change,
    input  logic             been_ready,
    input  logic [8:0]       target_code,
    output logic [IDX_W-1:0] char_idx,
    output logic [9:0]       correct_cnt,
    output logic [9:0]       error_cnt,
    output logic [7:0]       seconds,
    output logic [6:0]       wpm,
    output logic             done,
    output logic             finish_req
);

    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [2:0] ST_WAIT = 3'b000;
    localparam logic [2:0] ST_WORD = 3'b010;

    typedef enum logic [1:0] {PH_IDLE, PH_RUN, PH_DIV, PH_DONE} phase_t;

    phase_t            r_phase;
    logic [TICK_W-1:0] r_tick;
    logic [7:0]        r_sec;
    logic [9:0]        r_cor;
    logic [9:0]        r_err;
    logic [IDX_W-1:0]  r_idx;
    logic              r_press_prev;
    logic              r_finish;
    logic              r_done;
    logic [6:0]        r_wpm;
    // Divider state: r_step 0 loads operands, 1..14 run the shift/subtract steps, 15 stores the result.
    logic [3:0]        r_step;
    logic [7:0]        r_rem;
    logic [13:0]       r_quo;
    logic [7:0]        r_den;

    logic              w_level;
    logic              w_press;
    logic              w_ignored;
    logic              w_score;
    logic              w_match;
    logic              w_last_idx;
    logic              w_tick_wrap;
    logic              w_end_a;
    logic              w_end_b;
    logic              w_advance;
    logic [13:0]       w_numer;
    logic [8:0]        w_rem_sh;
    logic              w_ge;
    logic [7:0]        w_rem_sub;

    // A press is the first cycle in which the key-valid flag and the key's down bit are both high.
    assign w_level     = been_ready & key_down[last_change];
    assign w_press     = w_level & ~r_press_prev;
    // Presses of the shift keys and Enter are not part of the text.
    assign w_ignored   = (last_change == 9'h012) | (last_change == 9'h059) | (last_change == 9'h05A);
    assign w_score     = w_press & ~w_ignored;
    assign w_match     = (last_change == target_code);
    assign w_last_idx  = (r_idx == IDX_W'(TEXT_LEN - 1));
    assign w_tick_wrap = (r_tick == TICK_W'(CLK_HZ - 1));
`ifdef TYPING_STRICT_EN
    assign w_advance   = w_score;
`else
    assign w_advance   = w_score & w_match;
`endif
    assign w_end_a     = w_advance & w_last_idx;
    assign w_end_b     = w_tick_wrap & (({1'b0, r_sec} + 9'd1) == 9'(TIME_LIMIT));

    // The numerator is correct_cnt*12. It is 5 characters per word, scaled to one minute.
    assign w_numer     = 14'(r_cor) * 14'd12;
    assign w_rem_sh    = {r_rem, r_quo[13]};
    assign w_ge        = (w_rem_sh >= {1'b0, r_den});
    // The result is below r_den whenever it is used, so 8 bits of the difference are exact.
    assign w_rem_sub   = w_rem_sh[7:0] - r_den;

    // Phase sequencing, scoring, run timer and the sequential divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= PH_IDLE;
            r_tick       <= '0;
            r_sec        <= '0;
            r_cor        <= '0;
            r_err        <= '0;
            r_idx        <= '0;
            r_press_prev <= 1'b0;
            r_finish     <= 1'b0;
            r_done       <= 1'b0;
            r_wpm        <= '0;
            r_step       <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_den        <= '0;
        end else begin
            r_press_prev <= w_level;
            r_finish     <= 1'b0;
            case (r_phase)
                PH_IDLE: begin
                    if (state == ST_WORD) r_phase <= PH_RUN;
                end
                PH_RUN: begin
                    if (state == ST_WAIT) begin
                        r_phase <= PH_IDLE;
                        r_tick  <= '0;
                        r_sec   <= '0;
                        r_cor   <= '0;
                        r_err   <= '0;
                        r_idx   <= '0;
                    end else begin
                        r_tick <= w_tick_wrap ? '0 : r_tick + 1'b1;
                        if (w_tick_wrap && r_sec != 8'd255) r_sec <= r_sec + 8'd1;
                        if (w_score) begin
                            if (w_match) begin
                                if (r_cor != 10'd1023) r_cor <= r_cor + 10'd1;
                            end else begin
                                if (r_err != 10'd1023) r_err <= r_err + 10'd1;
                            end
                        end
                        if (w_advance && !w_last_idx) r_idx <= r_idx + 1'b1;
                        if (w_end_a || w_end_b) begin
                            r_finish <= 1'b1;
                            r_phase  <= PH_DIV;
                            r_step   <= '0;
                        end
                    end
                end
                PH_DIV: begin
                    if (r_step == 4'd0) begin
                        r_rem  <= '0;
                        r_quo  <= w_numer;
                        r_den  <= (r_sec == 8'd0) ? 8'd1 : r_sec;
                        r_step <= 4'd1;
                    end else if (r_step == 4'd15) begin
                        r_wpm   <= (|r_quo[13:7]) ? 7'd127 : r_quo[6:0];
                        r_done  <= 1'b1;
                        r_phase <= PH_DONE;
                    end else begin
                        r_rem  <= w_ge ? w_rem_sub : w_rem_sh[7:0];
                        r_quo  <= {r_quo[12:0], w_ge};
                        r_step <= r_step + 4'd1;
                    end
                end
                PH_DONE: begin
                    if (state == ST_WAIT) begin
                        r_phase <= PH_IDLE;
                        r_tick  <= '0;
                        r_sec   <= '0;
                        r_cor   <= '0;
                        r_err   <= '0;
                        r_idx   <= '0;
                        r_wpm   <= '0;
                        r_done  <= 1'b0;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

    assign char_idx    = r_idx;
    assign correct_cnt = r_cor;
    assign error_cnt   = r_err;
    assign seconds     = r_sec;
    assign wpm         = r_wpm;
    assign done        = r_done;
    assign finish_req  = r_finish;

endmodule
